// File: rtl/mrd_mem_pkt.sv
// rtl/mrd_mem_pkt.sv - shared memory geometry and write-back state encoding
package mrd_mem_pkt;

    localparam int unsigned wADDR        = 10;
    localparam int unsigned NUM_BANK     = 7;
    localparam int unsigned NUM_LANE     = 5;
    localparam logic [2:0]  INVALID_BANK = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mrd_lane2bank_xbar.sv
// rtl/mrd_lane2bank_xbar.sv - combinational lane-to-bank priority crossbar with conflict flag
module mrd_lane2bank_xbar
    import mrd_mem_pkt::*;
#(
    parameter int unsigned wADDR = mrd_mem_pkt::wADDR,
    parameter int unsigned wDATA = 18
) (
    input  logic [0:NUM_LANE-1][2:0]       bank_index_i,
    input  logic [0:NUM_LANE-1][wADDR-1:0] bank_addr_i,
    input  logic [0:NUM_LANE-1][wDATA-1:0] real_i,
    input  logic [0:NUM_LANE-1][wDATA-1:0] imag_i,
    output logic [0:NUM_BANK-1]            bank_hit_o,
    output logic [0:NUM_BANK-1][wADDR-1:0] bank_addr_o,
    output logic [0:NUM_BANK-1][wDATA-1:0] bank_real_o,
    output logic [0:NUM_BANK-1][wDATA-1:0] bank_imag_o,
    output logic                           conflict_o
);

    // Each bank takes the lowest-numbered lane aimed at it; any later lane aimed at an
    // already-claimed bank is a conflict. Unused lanes (index 7) match no bank.
    always_comb begin
        bank_hit_o  = '0;
        bank_addr_o = '0;
        bank_real_o = '0;
        bank_imag_o = '0;
        conflict_o  = 1'b0;
        for (int k = 0; k < NUM_BANK; k++) begin
            for (int j = 0; j < NUM_LANE; j++) begin
                if (bank_index_i[j] != INVALID_BANK && bank_index_i[j] == 3'(k)) begin
                    if (bank_hit_o[k]) begin
                        conflict_o = 1'b1;
                    end else begin
                        bank_hit_o[k]  = 1'b1;
                        bank_addr_o[k] = bank_addr_i[j];
                        bank_real_o[k] = real_i[j];
                        bank_imag_o[k] = imag_i[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mrd_rdx_wrback.sv
// rtl/mrd_rdx_wrback.sv - radix stage write-back: butterfly lanes to memory banks
module mrd_rdx_wrback
    import mrd_mem_pkt::*;
#(
    parameter int unsigned wADDR = mrd_mem_pkt::wADDR,
    parameter int unsigned wDATA = 18
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [11:0]                    n_wr,
    input  logic                           in_valid,
    input  logic [0:NUM_LANE-1][wDATA-1:0] in_real,
    input  logic [0:NUM_LANE-1][wDATA-1:0] in_imag,
    input  logic [0:NUM_LANE-1][2:0]       in_bank_index,
    input  logic [0:NUM_LANE-1][wADDR-1:0] in_bank_addr,
    output logic [0:NUM_BANK-1]            wren,
    output logic [0:NUM_BANK-1][wADDR-1:0] wraddr,
    output logic [0:NUM_BANK-1][wDATA-1:0] wrdata_real,
    output logic [0:NUM_BANK-1][wDATA-1:0] wrdata_imag,
    output logic                           busy,
    output logic                           wr_end,
    output logic [1:0]                     err
);

    wb_state_e state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] n_wr_q, n_wr_d;
    logic [1:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        wr_end_q, wr_end_d;
    logic        accept;

    logic [0:NUM_BANK-1]            wren_q, wren_d;
    logic [0:NUM_BANK-1][wADDR-1:0] wraddr_q, wraddr_d;
    logic [0:NUM_BANK-1][wDATA-1:0] wrdata_real_q, wrdata_real_d;
    logic [0:NUM_BANK-1][wDATA-1:0] wrdata_imag_q, wrdata_imag_d;

    logic [0:NUM_BANK-1]            xbar_hit;
    logic [0:NUM_BANK-1][wADDR-1:0] xbar_addr;
    logic [0:NUM_BANK-1][wDATA-1:0] xbar_real;
    logic [0:NUM_BANK-1][wDATA-1:0] xbar_imag;
    logic                           xbar_conflict;

    mrd_lane2bank_xbar #(
        .wADDR (wADDR),
        .wDATA (wDATA)
    ) u_xbar (
        .bank_index_i (in_bank_index),
        .bank_addr_i  (in_bank_addr),
        .real_i       (in_real),
        .imag_i       (in_imag),
        .bank_hit_o   (xbar_hit),
        .bank_addr_o  (xbar_addr),
        .bank_real_o  (xbar_real),
        .bank_imag_o  (xbar_imag),
        .conflict_o   (xbar_conflict)
    );

    // Stage sequencing, beat acceptance and sticky error tracking.
    // Wr leaves for Done one cycle after the last beat so wr_end trails the final wren.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_wr_d  = n_wr_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_wr_d  = n_wr;
                    cnt_d   = 12'd0;
                    err_d   = 2'b00;
                    state_d = (n_wr == 12'd0) ? ST_DONE : ST_WR;
                end
                if (in_valid) begin
                    err_d[1] = 1'b1;
                end
            end
            ST_WR: begin
                if (in_valid) begin
                    if (cnt_q < n_wr_q) begin
                        accept = 1'b1;
                        cnt_d  = cnt_q + 12'd1;
                    end else begin
                        err_d[1] = 1'b1;
                    end
                end
                if (cnt_q == n_wr_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    err_d[1] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && xbar_conflict) begin
            err_d[0] = 1'b1;
        end
    end

    // Bank write port next values: crossbar result on accepted beats, all-zero otherwise.
    always_comb begin
        wren_d        = '0;
        wraddr_d      = '0;
        wrdata_real_d = '0;
        wrdata_imag_d = '0;
        busy_d        = (state_d != ST_IDLE);
        wr_end_d      = (state_d == ST_DONE);
        if (accept) begin
            wren_d        = xbar_hit;
            wraddr_d      = xbar_addr;
            wrdata_real_d = xbar_real;
            wrdata_imag_d = xbar_imag;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            n_wr_q        <= '0;
            err_q         <= '0;
            busy_q        <= 1'b0;
            wr_end_q      <= 1'b0;
            wren_q        <= '0;
            wraddr_q      <= '0;
            wrdata_real_q <= '0;
            wrdata_imag_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            n_wr_q        <= n_wr_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            wr_end_q      <= wr_end_d;
            wren_q        <= wren_d;
            wraddr_q      <= wraddr_d;
            wrdata_real_q <= wrdata_real_d;
            wrdata_imag_q <= wrdata_imag_d;
        end
    end

    assign wren        = wren_q;
    assign wraddr      = wraddr_q;
    assign wrdata_real = wrdata_real_q;
    assign wrdata_imag = wrdata_imag_q;
    assign busy        = busy_q;
    assign wr_end      = wr_end_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mrd_rdx_wrback.sv
// tb/tb_mrd_rdx_wrback.sv - directed self-checking bench for mrd_rdx_wrback
module tb_mrd_rdx_wrback;

    localparam int unsigned WA = mrd_mem_pkt::wADDR;
    localparam int unsigned WD = 18;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [11:0]         n_wr;
    logic                in_valid;
    logic [0:4][WD-1:0]  in_real;
    logic [0:4][WD-1:0]  in_imag;
    logic [0:4][2:0]     in_bank_index;
    logic [0:4][WA-1:0]  in_bank_addr;
    logic [0:6]          wren;
    logic [0:6][WA-1:0]  wraddr;
    logic [0:6][WD-1:0]  wrdata_real;
    logic [0:6][WD-1:0]  wrdata_imag;
    logic                busy;
    logic                wr_end;
    logic [1:0]          err;

    int n_tests;
    int n_fail;

    mrd_rdx_wrback #(
        .wADDR (WA),
        .wDATA (WD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_wr          (n_wr),
        .in_valid      (in_valid),
        .in_real       (in_real),
        .in_imag       (in_imag),
        .in_bank_index (in_bank_index),
        .in_bank_addr  (in_bank_addr),
        .wren          (wren),
        .wraddr        (wraddr),
        .wrdata_real   (wrdata_real),
        .wrdata_imag   (wrdata_imag),
        .busy          (busy),
        .wr_end        (wr_end),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [0:4][2:0] idx, input logic [0:4][WA-1:0] addr, input int base);
        in_valid      = 1'b1;
        in_bank_index = idx;
        in_bank_addr  = addr;
        for (int j = 0; j < 5; j++) begin
            in_real[j] = WD'(base + j);
            in_imag[j] = WD'(base + 64 + j);
        end
    endtask

    task automatic do_start(input logic [11:0] n);
        start = 1'b1;
        n_wr  = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        n_wr          = '0;
        in_valid      = 1'b0;
        in_real       = '0;
        in_imag       = '0;
        in_bank_index = {5{3'd7}};
        in_bank_addr  = '0;
        tick();
        tick();
        check("rst_wren",   64'(wren),   64'h0);
        check("rst_busy",   64'(busy),   64'h0);
        check("rst_wr_end", 64'(wr_end), 64'h0);
        check("rst_err",    64'(err),    64'h0);
        check("rst_wraddr0", 64'(wraddr[0]), 64'h0);
        rst_n = 1'b1;
        tick();

        // Three clean beats to banks 0..2 at address 5
        do_start(12'd3);
        check("s1_busy", 64'(busy), 64'h1);
        for (int b = 0; b < 3; b++) begin
            set_beat({3'd0, 3'd1, 3'd2, 3'd7, 3'd7}, {10'd5, 10'd5, 10'd5, 10'd0, 10'd0}, 16 * b);
            tick();
            check("s1_wren",    64'(wren),           64'b1110000);
            check("s1_addr0",   64'(wraddr[0]),      64'd5);
            check("s1_addr2",   64'(wraddr[2]),      64'd5);
            check("s1_real1",   64'(wrdata_real[1]), 64'(16 * b + 1));
            check("s1_imag2",   64'(wrdata_imag[2]), 64'(16 * b + 64 + 2));
            check("s1_wr_end",  64'(wr_end),         64'h0);
        end
        in_valid = 1'b0;
        tick();
        check("s1_end_pulse", 64'(wr_end), 64'h1);
        check("s1_end_wren",  64'(wren),   64'h0);
        check("s1_end_busy",  64'(busy),   64'h1);
        tick();
        check("s1_end_clear", 64'(wr_end), 64'h0);
        check("s1_idle_busy", 64'(busy),   64'h0);
        check("s1_err",       64'(err),    64'h0);

        // Bank conflict: lanes 0 and 1 both aim at bank 3
        do_start(12'd1);
        set_beat({3'd3, 3'd3, 3'd4, 3'd7, 3'd7}, {10'd1, 10'd2, 10'd3, 10'd0, 10'd0}, 300);
        tick();
        in_valid = 1'b0;
        check("s2_wren",   64'(wren),           64'b0001100);
        check("s2_real3",  64'(wrdata_real[3]), 64'd300);
        check("s2_addr3",  64'(wraddr[3]),      64'd1);
        check("s2_real4",  64'(wrdata_real[4]), 64'd302);
        check("s2_addr4",  64'(wraddr[4]),      64'd3);
        check("s2_addr0",  64'(wraddr[0]),      64'd0);
        check("s2_err",    64'(err),            64'b01);
        tick();
        check("s2_wr_end", 64'(wr_end), 64'h1);
        tick();

        // Stray beat in Idle, then a fourth beat on a three-beat stage
        set_beat({3'd0, 3'd7, 3'd7, 3'd7, 3'd7}, {10'd9, 10'd0, 10'd0, 10'd0, 10'd0}, 500);
        tick();
        in_valid = 1'b0;
        check("s3_idle_wren", 64'(wren), 64'h0);
        check("s3_idle_err",  64'(err),  64'b11);
        do_start(12'd3);
        check("s3_err_clr",   64'(err),  64'b00);
        for (int b = 0; b < 3; b++) begin
            set_beat({3'd6, 3'd7, 3'd7, 3'd7, 3'd5}, {10'd7, 10'd0, 10'd0, 10'd0, 10'd8}, 32 * b);
            tick();
            check("s3_wren", 64'(wren), 64'b0000011);
            check("s3_real6", 64'(wrdata_real[6]), 64'(32 * b));
            check("s3_addr5", 64'(wraddr[5]), 64'd8);
        end
        set_beat({3'd0, 3'd7, 3'd7, 3'd7, 3'd7}, {10'd9, 10'd0, 10'd0, 10'd0, 10'd0}, 700);
        tick();
        in_valid = 1'b0;
        check("s3_extra_wren", 64'(wren),   64'h0);
        check("s3_extra_err",  64'(err),    64'b10);
        check("s3_wr_end",     64'(wr_end), 64'h1);
        tick();
        do_start(12'd1);
        check("s3_err_clr2", 64'(err), 64'b00);
        set_beat({3'd1, 3'd7, 3'd7, 3'd7, 3'd7}, {10'd4, 10'd0, 10'd0, 10'd0, 10'd0}, 40);
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Zero-length stage, then a start issued mid-stage
        do_start(12'd0);
        check("s4_zero_end",  64'(wr_end), 64'h1);
        check("s4_zero_wren", 64'(wren),   64'h0);
        check("s4_zero_busy", 64'(busy),   64'h1);
        tick();
        check("s4_zero_clr",  64'(wr_end), 64'h0);
        check("s4_zero_idle", 64'(busy),   64'h0);
        do_start(12'd2);
        do_start(12'd0);
        check("s4_ign_end",  64'(wr_end), 64'h0);
        check("s4_ign_busy", 64'(busy),   64'h1);
        for (int b = 0; b < 2; b++) begin
            set_beat({3'd2, 3'd7, 3'd7, 3'd7, 3'd7}, {10'd3, 10'd0, 10'd0, 10'd0, 10'd0}, 80 + b);
            tick();
            check("s4_wren",   64'(wren),   64'b0010000);
            check("s4_wr_end", 64'(wr_end), 64'h0);
        end
        in_valid = 1'b0;
        tick();
        check("s4_end", 64'(wr_end), 64'h1);
        check("s4_err", 64'(err),    64'h0);
        tick();

        // Reset in the middle of a four-beat stage
        do_start(12'd4);
        for (int b = 0; b < 2; b++) begin
            set_beat({3'd0, 3'd7, 3'd7, 3'd7, 3'd7}, {10'd2, 10'd0, 10'd0, 10'd0, 10'd0}, 900);
            tick();
        end
        check("s5_pre_wren", 64'(wren), 64'b1000000);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("s5_rst_wren",  64'(wren),           64'h0);
        check("s5_rst_real",  64'(wrdata_real[0]), 64'h0);
        check("s5_rst_addr",  64'(wraddr[0]),      64'h0);
        check("s5_rst_busy",  64'(busy),           64'h0);
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick();
            check("s5_no_end",  64'(wr_end), 64'h0);
            check("s5_no_busy", 64'(busy),   64'h0);
        end
        do_start(12'd1);
        set_beat({3'd7, 3'd4, 3'd7, 3'd7, 3'd7}, {10'd0, 10'd11, 10'd0, 10'd0, 10'd0}, 1000);
        tick();
        in_valid = 1'b0;
        check("s5_new_wren", 64'(wren),           64'b0000100);
        check("s5_new_addr", 64'(wraddr[4]),      64'd11);
        check("s5_new_real", 64'(wrdata_real[4]), 64'd1001);
        tick();
        check("s5_new_end",  64'(wr_end), 64'h1);
        check("s5_new_err",  64'(err),    64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
